// File: rtl/csa_stream_accumulator.sv
// Carry-save stream accumulator: one 3:2 compressor row folds one operand per cycle into S/C,
// then a single carry-propagate add per frame resolves the result onto a valid/ready output.
module csa_stream_accumulator #(
    parameter int WIDTH    = 32,
    parameter int IN_WIDTH = 16,
    parameter bit SIGNED   = 1'b1,
    parameter int CNT_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IN_WIDTH-1:0] in_data,
    input  logic                in_first,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    out_data,
    output logic [CNT_W-1:0]    out_count
);

    // Handshake: a transfer happens on a rising edge where valid & ready are both high; the
    // source holds payload while valid is high and unaccepted; ready never depends on valid.
    typedef enum logic [1:0] {IDLE, ACC, RESOLVE, OUT} state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] s_q, c_q, result_q;
    logic [WIDTH-1:0] x, a, b, maj;
    logic [CNT_W-1:0] count_q, out_count_q, cnt_base;
    logic             accept, fresh;

    generate
        if (IN_WIDTH == WIDTH) begin : g_ext_none
            assign x = in_data;
        end else if (SIGNED) begin : g_ext_signed
            assign x = {{(WIDTH-IN_WIDTH){in_data[IN_WIDTH-1]}}, in_data};
        end else begin : g_ext_zero
            assign x = {{(WIDTH-IN_WIDTH){1'b0}}, in_data};
        end
    endgenerate

    assign accept   = in_valid && in_ready;
    // Any beat taken in IDLE, or one flagged first, starts from an empty accumulator.
    assign fresh    = (state == IDLE) || in_first;
    assign a        = fresh ? '0 : s_q;
    assign b        = fresh ? '0 : c_q;
    assign cnt_base = fresh ? '0 : count_q;
    assign maj      = (a & b) | (a & x) | (b & x);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, ACC: begin
                if (accept) state_next = in_last ? RESOLVE : ACC;
            end
            RESOLVE:   state_next = OUT;
            OUT: begin
                if (out_ready) state_next = IDLE;
            end
            default:   state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE, ACC: in_ready  = 1'b1;
            OUT:       out_valid = 1'b1;
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q         <= '0;
            c_q         <= '0;
            count_q     <= '0;
            result_q    <= '0;
            out_count_q <= '0;
        end else begin
            if (accept) begin
                s_q     <= a ^ b ^ x;
                c_q     <= {maj[WIDTH-2:0], 1'b0};
                count_q <= (&cnt_base) ? cnt_base : cnt_base + CNT_W'(1);
            end
            if (state == RESOLVE) begin
                result_q    <= s_q + c_q;
                out_count_q <= count_q;
            end
        end
    end

    assign out_data  = result_q;
    assign out_count = out_count_q;

endmodule
